// File: rtl/sweep_sequencer.sv
// sweep_sequencer: steps the servo through 8 positions in ping-pong order.
// At each position it dwells for SETTLE_TICKS cycles, requests one
// measurement, then waits for pronto or TIMEOUT_TICKS cycles before stepping.
// Handshake: mede is a one-cycle request pulse. pronto is a completion strobe
// that is sampled only in MEASURE, including the cycle in which mede is high.
// There is no backpressure, and pronto outside MEASURE is ignored.
module sweep_sequencer #(
    parameter int SETTLE_TICKS  = 25000000,
    parameter int TIMEOUT_TICKS = 5000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        pronto,
    output logic        mede,
    output logic [2:0]  SEL,
    output logic [11:0] s_angulo,
    output logic        fim_ciclo,
    output logic        timeout,
    output logic [1:0]  db_estado
);

    localparam int MAX_TICKS = (SETTLE_TICKS > TIMEOUT_TICKS) ? SETTLE_TICKS : TIMEOUT_TICKS;
    localparam int TW        = $clog2(MAX_TICKS) + 1;
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_TICKS - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        STEP    = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] tmr, tmr_d;
    logic [2:0]    pos, pos_d;
    logic          up, up_d;
    logic          mede_d, fim_d, timeout_d;
    logic [11:0]   ang_d;
    logic          reversal;

    // BCD of 20*(p+1) degrees, hundreds in [11:8]
    function automatic logic [11:0] bcd_angle(input logic [2:0] p);
        logic [11:0] a;
        case (p)
            3'd0:    a = 12'h020;
            3'd1:    a = 12'h040;
            3'd2:    a = 12'h060;
            3'd3:    a = 12'h080;
            3'd4:    a = 12'h100;
            3'd5:    a = 12'h120;
            3'd6:    a = 12'h140;
            default: a = 12'h160;
        endcase
        return a;
    endfunction

    // the coming STEP turns around at either end of the sweep
    assign reversal  = (up && (pos == 3'd7)) || (!up && (pos == 3'd0));
    assign SEL       = pos;
    assign db_estado = state;

    // next-state, timer, position and registered-output pulse logic
    always_comb begin
        state_d   = state;
        tmr_d     = tmr;
        pos_d     = pos;
        up_d      = up;
        mede_d    = 1'b0;
        fim_d     = 1'b0;
        timeout_d = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_d = SETTLE;
                    tmr_d   = '0;
                end
            end
            SETTLE: begin
                if (!enable) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else if (tmr == SETTLE_LAST) begin
                    state_d = MEASURE;
                    tmr_d   = '0;
                    mede_d  = 1'b1;
                end else begin
                    tmr_d = tmr + TW'(1);
                end
            end
            MEASURE: begin
                // a started measurement finishes regardless of enable
                if (pronto) begin
                    state_d = STEP;
                    tmr_d   = '0;
                    fim_d   = reversal;
                end else if (tmr == TIMEOUT_LAST) begin
                    state_d   = STEP;
                    tmr_d     = '0;
                    fim_d     = reversal;
                    timeout_d = 1'b1;
                end else begin
                    tmr_d = tmr + TW'(1);
                end
            end
            STEP: begin
                if (up) begin
                    if (pos == 3'd7) begin
                        pos_d = 3'd6;
                        up_d  = 1'b0;
                    end else begin
                        pos_d = pos + 3'd1;
                    end
                end else begin
                    if (pos == 3'd0) begin
                        pos_d = 3'd1;
                        up_d  = 1'b1;
                    end else begin
                        pos_d = pos - 3'd1;
                    end
                end
                tmr_d   = '0;
                state_d = enable ? SETTLE : IDLE;
            end
            default: state_d = IDLE;
        endcase
        ang_d = bcd_angle(pos_d);
    end

    // state register plus registered position, angle and pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tmr       <= '0;
            pos       <= 3'd0;
            up        <= 1'b1;
            s_angulo  <= 12'h020;
            mede      <= 1'b0;
            fim_ciclo <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_d;
            tmr       <= tmr_d;
            pos       <= pos_d;
            up        <= up_d;
            s_angulo  <= ang_d;
            mede      <= mede_d;
            fim_ciclo <= fim_d;
            timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Testbench for sweep_sequencer with short dwell/timeout values.
module tb_sweep_sequencer;

  localparam int S = 4;
  localparam int T = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        pronto;
  logic        mede;
  logic [2:0]  SEL;
  logic [11:0] s_angulo;
  logic        fim_ciclo;
  logic        timeout;
  logic [1:0]  db_estado;

  sweep_sequencer #(.SETTLE_TICKS(S), .TIMEOUT_TICKS(T)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .pronto(pronto),
    .mede(mede), .SEL(SEL), .s_angulo(s_angulo), .fim_ciclo(fim_ciclo),
    .timeout(timeout), .db_estado(db_estado)
  );

  // clock/reset block
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] ep;
    logic [2:0]  pos;
    logic [11:0] ang;
    logic        fim;
    logic        tmo;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mede_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;
  int exp_fim = 0, exp_to = 0, obs_fim = 0, obs_to = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // reference model: position after k steps of the ping-pong sweep
  function automatic int pos_of(input int n);
    int p;
    p = n % 14;
    return (p <= 7) ? p : 14 - p;
  endfunction

  function automatic logic [11:0] angle_of(input int p);
    int v;
    logic [3:0] h, t, o;
    v = 20 * (p + 1);
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // scoreboard monitor
  logic [2:0] prev_sel = 3'd0;
  logic       prev_fim = 1'b0, prev_to = 1'b0;
  always @(negedge clock) begin
    exp_t        r;
    logic [31:0] e;
    if (!reset_n) begin
      prev_sel = SEL;
      prev_fim = 1'b0;
      prev_to  = 1'b0;
    end else begin
      if (mede) begin
        if (mede_q.size() == 0) begin
          check("mede_unexpected", 1, 0);
        end else begin
          e = mede_q.pop_front();
          check("mede_cycle", cyc, int'(e));
        end
      end
      if (fim_ciclo) obs_fim++;
      if (timeout) obs_to++;
      if (SEL != prev_sel) begin
        if (exp_q.size() == 0) begin
          check("step_unexpected", int'(SEL), int'(prev_sel));
        end else begin
          r = exp_q.pop_front();
          check("step_cycle", cyc, int'(r.ep) + 1);
          check("sel", int'(SEL), int'(r.pos));
          check("angle", int'(s_angulo), int'(r.ang));
          check("fim_ciclo", int'(prev_fim), int'(r.fim));
          check("timeout", int'(prev_to), int'(r.tmo));
        end
      end
      prev_sel = SEL;
      prev_fim = fim_ciclo;
      prev_to  = timeout;
    end
  end

  // driver tasks
  task automatic wait_mede(output int m, output bit ok);
    ok = 1'b0;
    m  = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (mede) begin
        ok = 1'b1;
        m  = cyc;
        break;
      end
    end
    if (!ok) check("mede_wait", 0, 1);
  endtask

  task automatic start_enable();
    enable = 1'b1;
    mede_q.push_back(32'(cyc + 1 + S));
  endtask

  // answer one measurement with pronto d cycles after mede (d>=T: timeout)
  task automatic measure(input int d, input bit drop, input bit expect_next,
                         output int ep, output bit ok);
    int   m;
    int   old;
    exp_t r;
    wait_mede(m, ok);
    ep = 0;
    if (!ok) return;
    if (drop) enable = 1'b0;
    check("state_measure", int'(db_estado), 2);
    ep    = (d <= T - 1) ? m + 1 + d : m + T;
    old   = k % 14;
    r.ep  = 32'(ep);
    r.fim = (old == 7) || (old == 0 && k > 0);
    r.tmo = (d > T - 1);
    k++;
    r.pos = 3'(pos_of(k));
    r.ang = angle_of(pos_of(k));
    exp_q.push_back(r);
    if (r.fim) exp_fim++;
    if (r.tmo) exp_to++;
    if (expect_next) mede_q.push_back(32'(ep + 1 + S));
    repeat (d) @(negedge clock);
    pronto = 1'b1;
    @(negedge clock);
    pronto = 1'b0;
  endtask

  task automatic wait_until(input int c);
    for (int i = 0; i < 50 && cyc < c; i++) @(negedge clock);
  endtask

  task automatic run_all();
    int ep;
    int m;
    bit ok;
    // reset and idle
    reset_n = 1'b0; enable = 1'b0; pronto = 1'b0;
    @(negedge clock);
    check("rst_sel", int'(SEL), 0);
    check("rst_angle", int'(s_angulo), 12'h020);
    check("rst_mede", int'(mede), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    check("idle_sel", int'(SEL), 0);
    check("idle_angle", int'(s_angulo), 12'h020);
    check("idle_state", int'(db_estado), 0);

    // random sweep through both reversals, ending at position 3
    start_enable();
    for (int i = 0; i < 16; i++) begin
      measure((i % 4 == 1) ? $urandom_range(T, T + 2) : $urandom_range(0, T - 1),
              1'b0, 1'b1, ep, ok);
      if (!ok) return;
    end
    measure(0, 1'b0, 1'b0, ep, ok);
    if (!ok) return;

    // drop enable two cycles into SETTLE at position 3
    wait_until(ep + 2);
    enable = 1'b0;
    @(negedge clock);
    check("drop_settle_state", int'(db_estado), 0);
    check("drop_settle_sel", int'(SEL), 3);
    repeat (3) @(negedge clock);
    check("idle_hold_state", int'(db_estado), 0);
    check("idle_hold_angle", int'(s_angulo), 12'h080);
    start_enable();
    measure(0, 1'b0, 1'b1, ep, ok);
    if (!ok) return;
    measure(0, 1'b0, 1'b1, ep, ok);
    if (!ok) return;

    // drop enable during MEASURE at position 5, pronto three cycles later
    measure(3, 1'b1, 1'b0, ep, ok);
    if (!ok) return;
    wait_until(ep + 1);
    check("drop_meas_state", int'(db_estado), 0);
    check("drop_meas_sel", int'(SEL), 6);
    check("drop_meas_angle", int'(s_angulo), 12'h140);

    // go to 7 and back to 6, then reset in the middle of MEASURE
    start_enable();
    measure(0, 1'b0, 1'b1, ep, ok);
    if (!ok) return;
    measure(0, 1'b0, 1'b1, ep, ok);
    if (!ok) return;
    wait_mede(m, ok);
    if (!ok) return;
    check("pre_reset_sel", int'(SEL), 6);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_sel", int'(SEL), 0);
    check("async_rst_angle", int'(s_angulo), 12'h020);
    check("async_rst_mede", int'(mede), 0);
    check("async_rst_state", int'(db_estado), 0);
    repeat (2) @(negedge clock);
    enable  = 1'b0;
    reset_n = 1'b1;
    k = 0;
    @(negedge clock);
    check("post_rst_state", int'(db_estado), 0);

    // sweep restarts upward from 0
    start_enable();
    measure(0, 1'b0, 1'b1, ep, ok);
    if (!ok) return;
    measure($urandom_range(0, T - 1), 1'b0, 1'b1, ep, ok);
    if (!ok) return;
    measure(0, 1'b1, 1'b0, ep, ok);
    if (!ok) return;
    wait_until(ep + 1);
    check("final_sel", int'(SEL), 3);
  endtask

  initial begin
    run_all();
    repeat (10) @(negedge clock);
    check("pending_steps", exp_q.size(), 0);
    check("pending_mede", mede_q.size(), 0);
    check("fim_count", obs_fim, exp_fim);
    check("timeout_count", obs_to, exp_to);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
